// File: rtl/pmp_chk_arb_pkg.sv
// Shared definitions for the sequential PMP checker/arbiter: pmpcfg field layout,
// access kinds, requester ids and FSM states.
package pmp_chk_arb_pkg;

  localparam int unsigned PmpCfgRBit  = 0;
  localparam int unsigned PmpCfgWBit  = 1;
  localparam int unsigned PmpCfgXBit  = 2;
  localparam int unsigned PmpCfgALo   = 3;
  localparam int unsigned PmpCfgAHi   = 4;
  localparam int unsigned PmpCfgLBit  = 7;

  localparam logic [1:0] PmpCfgAOff   = 2'd0;
  localparam logic [1:0] PmpCfgATor   = 2'd1;
  localparam logic [1:0] PmpCfgANa4   = 2'd2;
  localparam logic [1:0] PmpCfgANapot = 2'd3;

  localparam logic [1:0] PrivM = 2'd3;

  typedef enum logic [1:0] {AccX, AccR, AccW} pmp_acc_e;

  typedef enum logic {SrcI = 1'b0, SrcD = 1'b1} src_e;

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

endpackage

// File: rtl/pmp_chk_arb_if.sv
// Request/response bundle between the IF/MEM requesters (master) and the
// shared PMP checker (slave).
interface pmp_chk_arb_if #(
  parameter int unsigned PADDR_LEN = 34
) ();

  logic                 i_req;
  logic [PADDR_LEN-1:0] i_addr;
  logic [1:0]           i_priv;
  logic                 i_ack;

  logic                 d_req;
  logic [PADDR_LEN-1:0] d_addr;
  logic                 d_wr;
  logic [1:0]           d_priv;
  logic                 d_ack;

  logic                 rsp_valid;
  logic                 rsp_src;
  logic                 rsp_fault;
  logic                 rsp_hit;
  logic [3:0]           rsp_idx;

  modport master (
    output i_req, i_addr, i_priv, d_req, d_addr, d_wr, d_priv,
    input  i_ack, d_ack, rsp_valid, rsp_src, rsp_fault, rsp_hit, rsp_idx
  );

  modport slave (
    input  i_req, i_addr, i_priv, d_req, d_addr, d_wr, d_priv,
    output i_ack, d_ack, rsp_valid, rsp_src, rsp_fault, rsp_hit, rsp_idx
  );

endinterface

// File: rtl/pmp_entry_match.sv
// Combinational match of one PMP entry against a word address; instanced once
// and fed the entry selected by the scan index.
module pmp_entry_match import pmp_chk_arb_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [7:0]      cfg,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] prev_addr,
  input  logic [XLEN-1:0] word_addr,
  output logic            match,
  output logic            perm_x,
  output logic            perm_r,
  output logic            perm_w,
  output logic            lock
);

  logic [XLEN-1:0] napot_mask;
  logic            unused_cfg;

  // Trailing ones of addr plus the next bit up form the don't-care range.
  assign napot_mask = addr ^ (addr + XLEN'(1));

  always_comb begin
    match = 1'b0;
    case (cfg[PmpCfgAHi:PmpCfgALo])
      PmpCfgATor:   match = (word_addr >= prev_addr) && (word_addr < addr);
      PmpCfgANa4:   match = (word_addr == addr);
      PmpCfgANapot: match = ((word_addr & ~napot_mask) == (addr & ~napot_mask));
      default:      match = 1'b0;
    endcase
  end

  assign perm_x     = cfg[PmpCfgXBit];
  assign perm_r     = cfg[PmpCfgRBit];
  assign perm_w     = cfg[PmpCfgWBit];
  assign lock       = cfg[PmpCfgLBit];
  assign unused_cfg = ^cfg[6:5];

endmodule

// File: rtl/pmp_chk_arb.sv
// Round-robin arbiter in front of a single PMP match engine that scans entries
// 0..15 one per cycle and returns one allow/fault verdict per granted request.
module pmp_chk_arb import pmp_chk_arb_pkg::*; #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PADDR_LEN = 34
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [7:0]          pmpcfg  [16],
  input  logic [XLEN-1:0]     pmpaddr [16],
  pmp_chk_arb_if.slave        bus
);

  localparam int unsigned WordW = PADDR_LEN - 2;

  state_e          state_q;
  logic [3:0]      idx_q;
  logic [WordW-1:0] waddr_q;
  pmp_acc_e        acc_q;
  logic [1:0]      priv_q;
  src_e            src_q, last_src_q;
  logic            rsp_src_q, rsp_fault_q, rsp_hit_q;
  logic [3:0]      rsp_idx_q;

  logic            grant_i, grant_d;
  logic [7:0]      cur_cfg;
  logic [XLEN-1:0] cur_addr, prev_addr, word_addr;
  logic            match, perm_x, perm_r, perm_w, lock, perm;
  logic            any_on, is_m, hit_fault, miss_fault;
  logic            unused_addr_lsb;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle && !rst && !flush) begin
      if (bus.i_req && (!bus.d_req || last_src_q == SrcD)) begin
        grant_i = 1'b1;
      end else if (bus.d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  assign cur_cfg   = pmpcfg[idx_q];
  assign cur_addr  = pmpaddr[idx_q];
  assign prev_addr = (idx_q == 4'd0) ? '0 : pmpaddr[idx_q - 4'd1];
  assign word_addr = XLEN'(waddr_q);

  pmp_entry_match #(
    .XLEN(XLEN)
  ) u_match (
    .cfg      (cur_cfg),
    .addr     (cur_addr),
    .prev_addr(prev_addr),
    .word_addr(word_addr),
    .match    (match),
    .perm_x   (perm_x),
    .perm_r   (perm_r),
    .perm_w   (perm_w),
    .lock     (lock)
  );

  always_comb begin
    any_on = 1'b0;
    for (int k = 0; k < 16; k++) begin
      any_on |= (pmpcfg[k][PmpCfgAHi:PmpCfgALo] != PmpCfgAOff);
    end
  end

  always_comb begin
    case (acc_q)
      AccX:    perm = perm_x;
      AccW:    perm = perm_w;
      default: perm = perm_r;
    endcase
  end

  // M-mode bypasses unlocked entries; a miss only faults below M with PMP active.
  assign is_m       = (priv_q == PrivM);
  assign hit_fault  = !(is_m && !lock) && !perm;
  assign miss_fault = !is_m && any_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      waddr_q     <= '0;
      acc_q       <= AccX;
      priv_q      <= '0;
      src_q       <= SrcI;
      last_src_q  <= SrcD;
      rsp_src_q   <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_i) begin
            waddr_q    <= bus.i_addr[PADDR_LEN-1:2];
            acc_q      <= AccX;
            priv_q     <= bus.i_priv;
            src_q      <= SrcI;
            last_src_q <= SrcI;
            idx_q      <= '0;
            state_q    <= StScan;
          end else if (grant_d) begin
            waddr_q    <= bus.d_addr[PADDR_LEN-1:2];
            acc_q      <= bus.d_wr ? AccW : AccR;
            priv_q     <= bus.d_priv;
            src_q      <= SrcD;
            last_src_q <= SrcD;
            idx_q      <= '0;
            state_q    <= StScan;
          end
        end
        StScan: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (match) begin
            rsp_src_q   <= src_q;
            rsp_hit_q   <= 1'b1;
            rsp_idx_q   <= idx_q;
            rsp_fault_q <= hit_fault;
            state_q     <= StResp;
          end else if (idx_q == 4'd15) begin
            rsp_src_q   <= src_q;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_fault_q <= miss_fault;
            state_q     <= StResp;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.i_ack     = grant_i;
  assign bus.d_ack     = grant_d;
  assign bus.rsp_valid = (state_q == StResp) && !flush;
  assign bus.rsp_src   = rsp_src_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_idx   = rsp_idx_q;

  assign unused_addr_lsb = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

endmodule
